// File: rtl/dut_chk_pkg.sv
// Shared types, defaults and helpers for the end-of-path output checker.
// Optional halt-on-error behaviour is selected by DUT_CHK_HALT_ON_ERR_EN.
package dut_chk_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LAT_MAX    = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    HALT   = 2'd2
  } chk_state_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (val >= top) ? top : val + 32'd1;
  endfunction

endpackage

// File: rtl/dut_chk_delay_line.sv
// DATA_W x LATENCY shift register; data_out is the sample taken LATENCY edges ago.
module dut_chk_delay_line #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] pipe [LATENCY];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= data_in;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign data_out = pipe[LATENCY-1];

endmodule

// File: rtl/dut_out_checker.sv
// Passive checker comparing data_out against data_in delayed by LATENCY edges.
// Define DUT_CHK_HALT_ON_ERR_EN to stop checking after the first mismatch until clear.
module dut_out_checker
  import dut_chk_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 1,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic              err_sticky,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic [31:0]       first_err_cycle,
  output logic              checking,
  output chk_state_e        state
);

  localparam logic [3:0] WARM_LAST = 4'(LATENCY - 1);

  chk_state_e        next_state;
  logic [DATA_W-1:0] expected;
  logic [3:0]        warm_cnt;
  logic [31:0]       cycle_cnt;
  logic              do_cmp;
  logic              is_mismatch;

  dut_chk_delay_line #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .data_out (expected)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= WARMUP;
    else          state <= next_state;
  end

  // A compare is suppressed whenever clear is asserted on the same edge.
  always_comb begin
    next_state  = state;
    do_cmp      = 1'b0;
    is_mismatch = (data_out != expected);
    case (state)
      WARMUP: begin
        if (warm_cnt == WARM_LAST) next_state = CHECK;
      end
      CHECK: begin
        do_cmp = enable && !clear;
`ifdef DUT_CHK_HALT_ON_ERR_EN
        if (do_cmp && is_mismatch && !err_sticky) next_state = HALT;
`endif
      end
`ifdef DUT_CHK_HALT_ON_ERR_EN
      HALT: begin
        if (clear) next_state = CHECK;
      end
`endif
      default: next_state = WARMUP;
    endcase
  end

  assign checking = (state == CHECK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      warm_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == WARMUP) warm_cnt <= warm_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      match_count     <= '0;
      mismatch_count  <= '0;
      err_sticky      <= 1'b0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
      first_err_cycle <= '0;
    end else if (do_cmp) begin
      if (!is_mismatch) begin
        match_count <= CNT_W'(sat_inc(32'(match_count), CNT_W));
      end else begin
        mismatch_count <= CNT_W'(sat_inc(32'(mismatch_count), CNT_W));
        if (!err_sticky) begin
          err_sticky      <= 1'b1;
          first_err_exp   <= expected;
          first_err_got   <= data_out;
          first_err_cycle <= cycle_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_out_checker.sv
// Bench for dut_out_checker: two instances (LATENCY=1/CNT_W=16 and LATENCY=3/CNT_W=4)
// share one stimulus stream; a reference model feeds an expected queue per instance.
module tb_dut_out_checker;
  import dut_chk_pkg::*;

  localparam int DW    = 32;
  localparam int LAT_A = 1;
  localparam int CW_A  = 16;
  localparam int LAT_B = 3;
  localparam int CW_B  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out_a = '0;
  logic [DW-1:0] data_out_b = '0;

  logic [CW_A-1:0] match_count_a, mismatch_count_a;
  logic [CW_B-1:0] match_count_b, mismatch_count_b;
  logic            err_sticky_a, err_sticky_b, checking_a, checking_b;
  logic [DW-1:0]   first_err_exp_a, first_err_got_a, first_err_exp_b, first_err_got_b;
  logic [31:0]     first_err_cycle_a, first_err_cycle_b;
  chk_state_e      state_a, state_b;

  always #5 clk = ~clk;

  dut_out_checker #(.DATA_W(DW), .LATENCY(LAT_A), .CNT_W(CW_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .data_in(data_in), .data_out(data_out_a),
    .match_count(match_count_a), .mismatch_count(mismatch_count_a),
    .err_sticky(err_sticky_a), .first_err_exp(first_err_exp_a),
    .first_err_got(first_err_got_a), .first_err_cycle(first_err_cycle_a),
    .checking(checking_a), .state(state_a)
  );

  dut_out_checker #(.DATA_W(DW), .LATENCY(LAT_B), .CNT_W(CW_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .data_in(data_in), .data_out(data_out_b),
    .match_count(match_count_b), .mismatch_count(mismatch_count_b),
    .err_sticky(err_sticky_b), .first_err_exp(first_err_exp_b),
    .first_err_got(first_err_got_b), .first_err_cycle(first_err_cycle_b),
    .checking(checking_b), .state(state_b)
  );

  typedef struct packed {
    logic [15:0] match;
    logic [15:0] mism;
    logic        sticky;
    logic [31:0] fexp;
    logic [31:0] fgot;
    logic [31:0] fcyc;
    logic        checking;
    logic        warm;
  } exp_t;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = instance a, 1 = instance b.
  int unsigned m_edges [2];
  logic [15:0] m_match [2];
  logic [15:0] m_mism  [2];
  logic        m_sticky[2];
  logic        m_halt  [2];
  logic [31:0] m_fexp  [2];
  logic [31:0] m_fgot  [2];
  logic [31:0] m_fcyc  [2];

  logic [DW-1:0] hist[$];

  function automatic exp_t model_step(input int k, input logic rst, input logic en,
                                      input logic clr, input logic [31:0] exp_v,
                                      input logic [31:0] got_v);
    int unsigned lat;
    int unsigned cw;
    logic [15:0] cmax;
    logic        cmp;
    exp_t        r;
    lat  = (k == 0) ? LAT_A : LAT_B;
    cw   = (k == 0) ? CW_A : CW_B;
    cmax = 16'((32'd1 << cw) - 32'd1);
    if (!rst) begin
      m_edges[k] = 0; m_match[k] = '0; m_mism[k] = '0; m_sticky[k] = 1'b0;
      m_halt[k] = 1'b0; m_fexp[k] = '0; m_fgot[k] = '0; m_fcyc[k] = '0;
    end else begin
      cmp = (m_edges[k] >= lat) && !m_halt[k] && en && !clr;
      if (clr) begin
        m_match[k] = '0; m_mism[k] = '0; m_sticky[k] = 1'b0;
        m_halt[k] = 1'b0; m_fexp[k] = '0; m_fgot[k] = '0; m_fcyc[k] = '0;
      end else if (cmp) begin
        if (got_v == exp_v) begin
          if (m_match[k] != cmax) m_match[k] = m_match[k] + 16'd1;
        end else begin
          if (m_mism[k] != cmax) m_mism[k] = m_mism[k] + 16'd1;
          if (!m_sticky[k]) begin
            m_sticky[k] = 1'b1;
            m_fexp[k]   = exp_v;
            m_fgot[k]   = got_v;
            m_fcyc[k]   = m_edges[k];
`ifdef DUT_CHK_HALT_ON_ERR_EN
            m_halt[k]   = 1'b1;
`endif
          end
        end
      end
      m_edges[k] = m_edges[k] + 1;
    end
    r.match    = m_match[k];
    r.mism     = m_mism[k];
    r.sticky   = m_sticky[k];
    r.fexp     = m_fexp[k];
    r.fgot     = m_fgot[k];
    r.fcyc     = m_fcyc[k];
    r.checking = (m_edges[k] >= lat) && !m_halt[k];
    r.warm     = (m_edges[k] < lat);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, want);
    end
  endtask

  function automatic logic [31:0] rnd_mask(input int pct);
    return ($urandom_range(0, 99) < pct) ? ($urandom | 32'd1) : 32'd0;
  endfunction

  // One edge of stimulus: data path output = data_in from LATENCY edges ago, xor mask.
  task automatic drive(input logic [31:0] din, input logic en, input logic clr,
                       input logic rst, input logic [31:0] mask_a, input logic [31:0] mask_b);
    @(negedge clk);
    data_in    = din;
    enable     = en;
    clear      = clr;
    reset_n    = rst;
    data_out_a = hist[LAT_A-1] ^ mask_a;
    data_out_b = hist[LAT_B-1] ^ mask_b;
    exp_q_a.push_back(model_step(0, rst, en, clr, hist[LAT_A-1], data_out_a));
    exp_q_b.push_back(model_step(1, rst, en, clr, hist[LAT_B-1], data_out_b));
    hist.push_front(din);
    void'(hist.pop_back());
  endtask

  task automatic check_a(input exp_t e);
    chk("a.match_count",    32'(match_count_a),    32'(e.match));
    chk("a.mismatch_count", 32'(mismatch_count_a), 32'(e.mism));
    chk("a.err_sticky",     32'(err_sticky_a),     32'(e.sticky));
    chk("a.first_err_exp",  first_err_exp_a,       e.fexp);
    chk("a.first_err_got",  first_err_got_a,       e.fgot);
    chk("a.first_err_cycle", first_err_cycle_a,    e.fcyc);
    chk("a.checking",       32'(checking_a),       32'(e.checking));
    chk("a.warmup",         32'(state_a == WARMUP), 32'(e.warm));
  endtask

  task automatic check_b(input exp_t e);
    chk("b.match_count",    32'(match_count_b),    32'(e.match));
    chk("b.mismatch_count", 32'(mismatch_count_b), 32'(e.mism));
    chk("b.err_sticky",     32'(err_sticky_b),     32'(e.sticky));
    chk("b.first_err_exp",  first_err_exp_b,       e.fexp);
    chk("b.first_err_got",  first_err_got_b,       e.fgot);
    chk("b.first_err_cycle", first_err_cycle_b,    e.fcyc);
    chk("b.checking",       32'(checking_b),       32'(e.checking));
    chk("b.warmup",         32'(state_b == WARMUP), 32'(e.warm));
  endtask

  // Monitor: registered outputs are sampled 1 ns after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() > 0) check_a(exp_q_a.pop_front());
      if (exp_q_b.size() > 0) check_b(exp_q_b.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) hist.push_back('0);

    repeat (2) drive($urandom, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) drive(32'(i + 1), 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    drive(32'd11, 1'b1, 1'b0, 1'b1, 32'h3, 32'd0);
    for (int i = 0; i < 3; i++) drive(32'(i + 12), 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    drive(32'd15, 1'b1, 1'b0, 1'b1, 32'h2, 32'h5);
    for (int i = 0; i < 3; i++) drive($urandom, 1'b0, 1'b0, 1'b1, 32'h8, 32'h8);
    drive($urandom, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1);
    for (int i = 0; i < 40; i++) drive($urandom, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);

    for (int i = 0; i < 6; i++) drive($urandom, 1'b1, 1'b0, 1'b1, rnd_mask(20), rnd_mask(20));
    drive($urandom, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) drive($urandom, 1'b1, 1'b0, 1'b1, rnd_mask(30), rnd_mask(30));

    for (int i = 0; i < 400; i++) begin
      drive($urandom,
            $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) != 0,
            rnd_mask(15), rnd_mask(15));
    end

    repeat (2) @(negedge clk);
    chk("queue_a_drained", exp_q_a.size(), 32'd0);
    chk("queue_b_drained", exp_q_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dut_out_checker.md
Name: dut_out_checker

Overview:
- Passive end-of-path checker for the registered data path.
- Samples data_in every cycle into a delay line of LATENCY stages.
- Compares each delayed value against data_out. Counts matches and mismatches, and captures the first mismatch.
- Sits beside the data-path block in the sim top, on the same clk/reset_n, and gives the testbench a cycle-accurate self-check.

Parameters:
- DATA_W, 32: width of data_in/data_out; unsigned.
- LATENCY, 1: clock edges from data_in sample to data_out valid; legal 1..8.
- CNT_W, 16: width of match/mismatch counters.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset; clock clk.
- enable  input  1  gates comparison and counting; delay line always shifts.
- clear  input  1  synchronous clear of counters, sticky error and capture registers.
- data_in  input  DATA_W  stimulus value driven into the data path.
- data_out  input  DATA_W  data path output under check.
- match_count  output  CNT_W  number of matching compares; saturates.
- mismatch_count  output  CNT_W  number of mismatching compares; saturates.
- err_sticky  output  1  set on first mismatch; held until clear or reset.
- first_err_exp  output  DATA_W  expected value at first mismatch.
- first_err_got  output  DATA_W  data_out value at first mismatch.
- first_err_cycle  output  32  cycle index of first mismatch; index 0 = first edge after reset release.
- checking  output  1  high while state is CHECK.

Behaviour:
- Reset (reset_n==0 at posedge):
  - All outputs 0; delay line 0; cycle counter 0; warmup counter 0; state WARMUP.
  - Reset mid-operation aborts everything; no partial counts retained.
- Delay line: pipe[0] <= data_in each non-reset edge; pipe[i] <= pipe[i-1]. Expected value = pipe[LATENCY-1] before the edge.
- Cycle counter: increments every non-reset edge; 32-bit; wraps silently.
- WARMUP:
  - Increments warmup counter each edge; no compares.
  - After LATENCY edges, go to CHECK (with LATENCY=1, CHECK from the 2nd edge).
  - clear is honoured in WARMUP.
- CHECK, on an edge with enable=1:
  - data_out == expected: match_count++.
  - Otherwise: mismatch_count++.
  - If err_sticky==0, also set err_sticky and load first_err_exp, first_err_got and first_err_cycle, all in the same edge.
  - enable=0: no compare, no count change; delay line still shifts.
- Counters stop at 2^CNT_W-1 and do not wrap.
- clear=1:
  - Counters, err_sticky and first_err_* go to 0 at that edge.
  - A compare in the same edge is discarded; clear wins.
  - State and delay line are unaffected, except HALT -> CHECK (see Optional Feature).
- Update timing: outputs are registered; a count change is visible the cycle after the compare edge.

Optional Feature:
- Macro: DUT_CHK_HALT_ON_ERR_EN.
- Defined:
  - Adds state HALT, entered on the edge that records the first mismatch.
  - In HALT: no compares, counters frozen, checking=0; clear returns to CHECK.
- Undefined: no HALT state; checking continues after errors.

Decomposition:
- Package dut_chk_pkg:
  - typedef chk_state_e {WARMUP, CHECK, HALT}.
  - Constants DATA_W_DEF=32, LAT_MAX=8, CNT_W_DEF=16.
  - Saturating-increment function.
- Sub-module dut_chk_delay_line: parameterised DATA_W x LATENCY shift register with synchronous reset; the checker instantiates one.

Test Plan:
- Reset then in-order stream: LATENCY=1, reset_n low 2 cycles, bench models a 1-cycle register, data_in 1..10 on edges 0..9 -> match_count=9, mismatch_count=0, err_sticky=0.
- Single mismatch: data_in=5 at edge 3, data_out forced to 6 at edge 4 -> mismatch_count=1, err_sticky=1, first_err_exp=5, first_err_got=6, first_err_cycle=4.
- Second mismatch: exp 7/got 9 at edge 8 -> mismatch_count=2; first_err_* unchanged (5/6/4).
- Saturation: CNT_W=4, 20 matching edges -> match_count=15, stays at 15.
- enable and clear: enable=0 for 3 edges -> counts unchanged; clear with a mismatch on the same edge -> all counts 0, err_sticky=0.
- LATENCY=3 and mid-run reset:
  - No compares on edges 0..2; first compare on edge 3.
  - reset_n low on edge 6 -> all outputs 0, state WARMUP.
  - With DUT_CHK_HALT_ON_ERR_EN: after a mismatch, checking=0 and further mismatches are not counted until clear.
